// File: rtl/altr_hps_and_gate_seq.sv
// altr_hps_and_gate_seq: paced thermometer sequencer for altr_hps_and enable gates; ALTR_HPS_GATE_SEQ_BYPASS_EN adds gate_bypass
module altr_hps_and_gate_seq #(
  parameter int NUM_GATES = 4,
  parameter int GAP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_req,
  input  logic [GAP_W-1:0]     gap,
`ifdef ALTR_HPS_GATE_SEQ_BYPASS_EN
  input  logic                 gate_bypass,
`endif
  output logic [NUM_GATES-1:0] gate_en,
  output logic                 en_ack,
  output logic                 seq_busy
);
  localparam int IW = $clog2(NUM_GATES + 1);
  localparam logic [IW-1:0] N_IDX = IW'(NUM_GATES);
  typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DN} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [GAP_W-1:0] gcnt, gcnt_n, gm1;
  logic [NUM_GATES-1:0] therm;
  assign gm1 = (gap == '0) ? '0 : gap - 1'b1;
  always_comb begin
    state_n = state;
    idx_n = idx;
    gcnt_n = gcnt;
    case (state)
      OFF: if (en_req) begin
        state_n = RAMP_UP;
        idx_n = IW'(1);
        gcnt_n = gm1;
      end
      RAMP_UP: if (!en_req) begin
        state_n = RAMP_DN;
        idx_n = idx - 1'b1;
        gcnt_n = gm1;
      end else if (gcnt != '0) begin
        gcnt_n = gcnt - 1'b1;
      end else if (idx == N_IDX) begin
        state_n = ON;
      end else begin
        idx_n = idx + 1'b1;
        gcnt_n = gm1;
      end
      ON: if (!en_req) begin
        state_n = RAMP_DN;
        idx_n = idx - 1'b1;
        gcnt_n = gm1;
      end
      default: if (en_req) begin
        state_n = RAMP_UP;
        idx_n = idx + 1'b1;
        gcnt_n = gm1;
      end else if (gcnt != '0) begin
        gcnt_n = gcnt - 1'b1;
      end else if (idx == '0) begin
        state_n = OFF;
      end else begin
        idx_n = idx - 1'b1;
        gcnt_n = gm1;
      end
    endcase
`ifdef ALTR_HPS_GATE_SEQ_BYPASS_EN
    if (gate_bypass) begin
      state_n = ON;
      idx_n = N_IDX;
      gcnt_n = '0;
    end
`endif
    therm = '0;
    for (int i = 0; i < NUM_GATES; i++) therm[i] = i < int'(idx_n);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      idx <= '0;
      gcnt <= '0;
      gate_en <= '0;
      en_ack <= 1'b0;
      seq_busy <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      gcnt <= gcnt_n;
      gate_en <= therm;
      en_ack <= state_n == ON;
      seq_busy <= state_n == RAMP_UP || state_n == RAMP_DN;
    end
  end
endmodule

// File: tb/tb_altr_hps_and_gate_seq.sv
// tb_altr_hps_and_gate_seq: directed-vector bench for altr_hps_and_gate_seq (NUM_GATES=4, GAP_W=4)
module tb_altr_hps_and_gate_seq;
  logic clk = 1'b0;
  logic rst, en_req;
  logic [3:0] gap;
  logic [3:0] gate_en;
  logic en_ack, seq_busy;
  int n_vec = 0;
  int n_err = 0;
`ifdef ALTR_HPS_GATE_SEQ_BYPASS_EN
  logic gate_bypass = 1'b0;
`endif
  always #5 clk = ~clk;
  altr_hps_and_gate_seq #(.NUM_GATES(4), .GAP_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .en_req(en_req),
    .gap(gap),
`ifdef ALTR_HPS_GATE_SEQ_BYPASS_EN
    .gate_bypass(gate_bypass),
`endif
    .gate_en(gate_en),
    .en_ack(en_ack),
    .seq_busy(seq_busy)
  );
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:0] ge, input logic ack, input logic busy);
    chk({tag, ".gate_en"}, 32'(gate_en), 32'(ge));
    chk({tag, ".en_ack"}, 32'(en_ack), 32'(ack));
    chk({tag, ".seq_busy"}, 32'(seq_busy), 32'(busy));
  endtask
  initial begin
    rst = 1'b1;
    en_req = 1'b1;
    gap = 4'd3;
    step(1); chk_all("rst0", 4'b0000, 0, 0);
    step(1); chk_all("rst1", 4'b0000, 0, 0);
    rst = 1'b0;
    step(1); chk_all("up_e0", 4'b0001, 0, 1);
    step(2); chk_all("up_e2", 4'b0001, 0, 1);
    step(1); chk_all("up_e3", 4'b0011, 0, 1);
    step(3); chk_all("up_e6", 4'b0111, 0, 1);
    step(3); chk_all("up_e9", 4'b1111, 0, 1);
    step(2); chk_all("up_e11", 4'b1111, 0, 1);
    step(1); chk_all("up_e12", 4'b1111, 1, 0);
    step(2); chk_all("on_hold", 4'b1111, 1, 0);
    gap = 4'd0;
    en_req = 1'b0;
    step(1); chk_all("dn_d0", 4'b0111, 0, 1);
    step(1); chk_all("dn_d1", 4'b0011, 0, 1);
    step(1); chk_all("dn_d2", 4'b0001, 0, 1);
    step(1); chk_all("dn_d3", 4'b0000, 0, 1);
    step(1); chk_all("dn_off", 4'b0000, 0, 0);
    gap = 4'd2;
    en_req = 1'b1;
    step(1); chk_all("rev_u0", 4'b0001, 0, 1);
    step(2); chk_all("rev_u2", 4'b0011, 0, 1);
    en_req = 1'b0;
    step(1); chk_all("rev_drop", 4'b0001, 0, 1);
    en_req = 1'b1;
    step(1); chk_all("rev_raise", 4'b0011, 0, 1);
    en_req = 1'b0;
    step(1); chk_all("rev_drop2", 4'b0001, 0, 1);
    step(1); chk_all("rev_wait", 4'b0001, 0, 1);
    step(1); chk_all("rev_zero", 4'b0000, 0, 1);
    step(1); chk_all("rev_settle", 4'b0000, 0, 1);
    step(1); chk_all("rev_off", 4'b0000, 0, 0);
    en_req = 1'b1;
    step(1); chk_all("gc_u0", 4'b0001, 0, 1);
    gap = 4'd5;
    step(1); chk_all("gc_u1", 4'b0001, 0, 1);
    step(1); chk_all("gc_u2", 4'b0011, 0, 1);
    step(4); chk_all("gc_u6", 4'b0011, 0, 1);
    step(1); chk_all("gc_u7", 4'b0111, 0, 1);
    rst = 1'b1;
    step(1); chk_all("rst_mid", 4'b0000, 0, 0);
    rst = 1'b0;
    en_req = 1'b0;
    step(1); chk_all("post_rst", 4'b0000, 0, 0);
`ifdef ALTR_HPS_GATE_SEQ_BYPASS_EN
    gap = 4'd0;
    gate_bypass = 1'b1;
    step(1); chk_all("byp_on", 4'b1111, 1, 0);
    step(1); chk_all("byp_hold", 4'b1111, 1, 0);
    gate_bypass = 1'b0;
    step(1); chk_all("byp_rel", 4'b0111, 0, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
